// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier accumulator stage.
// Holds the product width, FSM state type and default sizing.
package booth_pkg;

   localparam int PROD_W    = 8;
   localparam int ACC_W_DEF = 16;
   localparam int LEN_DEF   = 4;

   typedef enum logic {
      ST_ACC,
      ST_HOLD
   } state_t;

endpackage

// File: rtl/booth_acc_add.sv
// Combinational signed add of a sign-extended product into the accumulator,
// with overflow detect; saturates instead of wrapping when BOOTH_ACC_SAT_EN is defined.
module booth_acc_add
   import booth_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W:0] wide;

   // One guard bit holds the true result of any ACC_W + PROD_W signed add.
   assign wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
   assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef BOOTH_ACC_SAT_EN
   always_comb begin
      if (ovf) begin
         sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sum = wide[ACC_W-1:0];
      end
   end
`else
   assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/booth_acc.sv
// Groups LEN signed Booth products into one ACC_W-bit sum with sticky overflow.
// Define BOOTH_ACC_SAT_EN to saturate each add instead of wrapping.
module booth_acc
   import booth_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN   = LEN_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_ovf
);

   localparam logic [7:0] CNT_LAST = 8'(LEN - 1);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, add_sum;
   logic [7:0]       cnt;
   logic             ovf, add_ovf;
   logic             accept, last;

   booth_acc_add #(.ACC_W(ACC_W)) u_add (
      .acc  (acc),
      .prod (in_prod),
      .sum  (add_sum),
      .ovf  (add_ovf)
   );

   assign last = (cnt == CNT_LAST);

   // Handshake outputs decode the state register only, never an input.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_ACC: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid && last) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_ACC;
         end
         default: state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= ST_ACC;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
         out_sum <= '0;
         out_ovf <= 1'b0;
      end else if (accept) begin
         acc <= add_sum;
         cnt <= cnt + 8'd1;
         ovf <= ovf | add_ovf;
         if (last) begin
            out_sum <= add_sum;
            out_ovf <= ovf | add_ovf;
         end
      end else if (state == ST_HOLD && out_ready) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_booth_acc.sv
// Scoreboard bench for booth_acc: three instances (16b/LEN4, 9b/LEN8, 16b/LEN1)
// checked against an integer reference model; honours BOOTH_ACC_SAT_EN.
module tb_booth_acc;

   typedef struct {
      int sum;
      bit ovf;
   } exp_t;

   localparam int AW [3] = '{16, 9, 16};
   localparam int LN [3] = '{4, 8, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid  [3];
   logic [7:0] in_prod   [3];
   logic       out_ready [3];
   logic       in_ready  [3];
   logic       out_valid [3];
   logic       out_ovf   [3];
   logic [15:0] s0, s2;
   logic [8:0]  s1;
   int          sum_v [3];

   int checks = 0;
   int errors = 0;

   exp_t exp_q [3][$];
   int   m_acc [3];
   int   m_cnt [3];
   bit   m_ovf [3];

   always #5 clk = ~clk;

   booth_acc #(.ACC_W(16), .LEN(4)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_prod(in_prod[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_sum(s0), .out_ovf(out_ovf[0]));

   booth_acc #(.ACC_W(9), .LEN(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_prod(in_prod[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_sum(s1), .out_ovf(out_ovf[1]));

   booth_acc #(.ACC_W(16), .LEN(1)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_prod(in_prod[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_sum(s2), .out_ovf(out_ovf[2]));

   assign sum_v[0] = int'($signed(s0));
   assign sum_v[1] = int'($signed(s1));
   assign sum_v[2] = int'($signed(s2));

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: plain integer sum per product, range-checked against ACC_W.
   task automatic model_add(input int idx, input int p);
      int v, mx, mn;
      mx = (1 << (AW[idx] - 1)) - 1;
      mn = -(1 << (AW[idx] - 1));
      v  = m_acc[idx] + p;
      if (v > mx || v < mn) begin
         m_ovf[idx] = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
         v = (v > mx) ? mx : mn;
`else
         v = (v > mx) ? v - (1 << AW[idx]) : v + (1 << AW[idx]);
`endif
      end
      m_acc[idx] = v;
      m_cnt[idx]++;
      if (m_cnt[idx] == LN[idx]) begin
         exp_q[idx].push_back('{sum: m_acc[idx], ovf: m_ovf[idx]});
         m_acc[idx] = 0;
         m_cnt[idx] = 0;
         m_ovf[idx] = 1'b0;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0;
         m_cnt[i] = 0;
         m_ovf[i] = 1'b0;
      end
   endtask

   // Offer one product and hold it until the DUT takes it (bounded wait).
   task automatic push(input int idx, input int p);
      int t;
      in_valid[idx] = 1'b1;
      in_prod[idx]  = 8'(p);
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready[idx]) break;
         t++;
         if (t > 100) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout[%0d]: in_ready stayed %0b, expected 1", idx, in_ready[idx]);
            in_valid[idx] = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      in_valid[idx] = 1'b0;
      model_add(idx, p);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (out_valid[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out[%0d]: got sum %0d, no result expected", i, sum_v[i]);
               end else begin
                  check($sformatf("out_sum[%0d]", i), sum_v[i], exp_q[i][0].sum);
                  check($sformatf("out_ovf[%0d]", i), int'(out_ovf[i]), int'(exp_q[i][0].ovf));
                  if (out_ready[i]) void'(exp_q[i].pop_front());
               end
            end
         end
      end
   end

   initial begin
      int t;
      for (int i = 0; i < 3; i++) begin
         in_valid[i]  = 1'b0;
         in_prod[i]   = '0;
         out_ready[i] = 1'b1;
      end
      model_reset();
      idle(2);
      rst = 1'b0;

      // Reset state
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_in_ready[%0d]", i), int'(in_ready[i]), 1);
         check($sformatf("rst_out_valid[%0d]", i), int'(out_valid[i]), 0);
         check($sformatf("rst_out_sum[%0d]", i), sum_v[i], 0);
         check($sformatf("rst_out_ovf[%0d]", i), int'(out_ovf[i]), 0);
      end

      // Directed group: latency and single-cycle HOLD
      push(0, 12); push(0, -8); push(0, 64); push(0, -56);
      check("lat_out_valid", int'(out_valid[0]), 1);
      check("lat_in_ready", int'(in_ready[0]), 0);
      idle(1);
      check("b2b_in_ready", int'(in_ready[0]), 1);
      check("b2b_out_valid", int'(out_valid[0]), 0);

      // Stalled output: result frozen, upstream product ignored
      out_ready[0] = 1'b0;
      push(0, 12); push(0, -8); push(0, 64); push(0, -56);
      in_valid[0] = 1'b1;
      in_prod[0]  = 8'd7;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_in_ready", int'(in_ready[0]), 0);
         check("stall_out_valid", int'(out_valid[0]), 1);
         check("stall_sum", sum_v[0], 12);
      end
      @(posedge clk);
      #1;
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      idle(1);
      check("release_in_ready", int'(in_ready[0]), 1);
      push(0, 1); push(0, 2); push(0, 3); push(0, 4);

      // Overflow at ACC_W=9: eight products of 64
      for (int k = 0; k < 8; k++) push(1, 64);
      @(negedge clk);
`ifdef BOOTH_ACC_SAT_EN
      check("ovf9_sum", sum_v[1], 255);
`else
      check("ovf9_sum", sum_v[1], 0);
`endif
      check("ovf9_flag", int'(out_ovf[1]), 1);
      idle(1);

      // Random idle gaps across three groups of -1
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 1)));
         push(0, -1);
      end
      idle(1);

      // Mid-group reset discards partial state
      push(0, 5); push(0, 5);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      model_reset();
      check("midrst_in_ready", int'(in_ready[0]), 1);
      check("midrst_out_valid", int'(out_valid[0]), 0);
      check("midrst_out_sum", sum_v[0], 0);
      check("midrst_out_ovf", int'(out_ovf[0]), 0);
      for (int k = 0; k < 4; k++) push(0, 5);
      idle(1);

      // LEN=1 back-to-back
      push(2, 3);
      push(2, -3);
      idle(1);

      // Random legal products
      for (int k = 0; k < 16; k++) push(0, int'($urandom_range(120, 0)) - 56);

      t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      for (int i = 0; i < 3; i++)
         check($sformatf("drain[%0d]", i), exp_q[i].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
